// File: rtl/pipe_pkg.sv
// Shared constants for the front-end pipeline registers: NOP encoding, reset PC
// default and the layout of the packed ID->EX control bundle.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          CTRL_W_DEFAULT   = 8;

    // Bit positions inside the control bundle; an all-zero bundle is a bubble.
    localparam int CTRL_REGWRITE_BIT = 0;
    localparam int CTRL_MEMREAD_BIT  = 1;
    localparam int CTRL_MEMWRITE_BIT = 2;
    localparam int CTRL_ALU_LSB      = 3;
    localparam int CTRL_ALU_MSB      = 7;

endpackage

// File: rtl/pipe_front_regs_if.sv
// Bundle between fetch/decode/hazard unit (master) and pipe_front_regs (slave).
// ValidD/ValidE qualify stage contents; there is no ready: back-pressure is StallF/StallD, squash is FlushD/FlushE.
interface pipe_front_regs_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
);
    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              FlushE;
    logic              PCSrcE;
    logic [XLEN-1:0]   PCTargetE;
    logic [31:0]       InstrF;
    logic [CTRL_W-1:0] CtrlD;
    logic [4:0]        Rs1D;
    logic [4:0]        Rs2D;
    logic [4:0]        RdD;
    logic [XLEN-1:0]   RD1D;
    logic [XLEN-1:0]   RD2D;
    logic [XLEN-1:0]   ImmD;

    logic [XLEN-1:0]   PCF;
    logic [31:0]       InstrD;
    logic [XLEN-1:0]   PCD;
    logic [XLEN-1:0]   PCPlus4D;
    logic              ValidD;
    logic [CTRL_W-1:0] CtrlE;
    logic [4:0]        Rs1E;
    logic [4:0]        Rs2E;
    logic [4:0]        RdE;
    logic [XLEN-1:0]   RD1E;
    logic [XLEN-1:0]   RD2E;
    logic [XLEN-1:0]   ImmE;
    logic [XLEN-1:0]   PCE;
    logic [XLEN-1:0]   PCPlus4E;
    logic              ValidE;
    logic [31:0]       CycleCnt;
    logic [31:0]       StallCnt;
    logic [31:0]       FlushCnt;

    modport master (
        output StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE, InstrF,
               CtrlD, Rs1D, Rs2D, RdD, RD1D, RD2D, ImmD,
        input  PCF, InstrD, PCD, PCPlus4D, ValidD, CtrlE, Rs1E, Rs2E, RdE,
               RD1E, RD2E, ImmE, PCE, PCPlus4E, ValidE, CycleCnt, StallCnt, FlushCnt
    );

    modport slave (
        input  StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE, InstrF,
               CtrlD, Rs1D, Rs2D, RdD, RD1D, RD2D, ImmD,
        output PCF, InstrD, PCD, PCPlus4D, ValidD, CtrlE, Rs1E, Rs2E, RdE,
               RD1E, RD2E, ImmE, PCE, PCPlus4E, ValidE, CycleCnt, StallCnt, FlushCnt
    );

endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset to zero, clr beats en.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX registers with stall/flush/redirect control.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_front_regs
    import pipe_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int              CTRL_W   = CTRL_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_front_regs_if.slave   bus
);

    logic [XLEN-1:0] pcf;
    logic [XLEN-1:0] pcf_plus4;

    assign pcf_plus4 = pcf + XLEN'(4);

    // A redirect outranks a stall so a taken branch is never dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf <= RESET_PC;
        end else if (bus.PCSrcE) begin
            pcf <= bus.PCTargetE;
        end else if (!bus.StallF) begin
            pcf <= pcf_plus4;
        end
    end

    assign bus.PCF = pcf;

    // IF/ID: the instruction is stored XOR NOP so the zero reset/clear value reads back as NOP.
    localparam int FD_W = 32 + 2 * XLEN + 1;

    logic [FD_W-1:0] fd_d;
    logic [FD_W-1:0] fd_q;
    logic [31:0]     instr_x;
    logic [XLEN-1:0] pcd;
    logic [XLEN-1:0] pcplus4d;
    logic            validd;

    assign fd_d = {bus.InstrF ^ NOP_INSTR, pcf, pcf_plus4, 1'b1};

    pipe_reg #(.W(FD_W)) u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!bus.StallD),
        .clr   (bus.FlushD),
        .d     (fd_d),
        .q     (fd_q)
    );

    assign {instr_x, pcd, pcplus4d, validd} = fd_q;
    assign bus.InstrD   = instr_x ^ NOP_INSTR;
    assign bus.PCD      = pcd;
    assign bus.PCPlus4D = pcplus4d;
    assign bus.ValidD   = validd;

    // ID/EX: never stalled; a flush zeroes everything so the bubble has no side effects and RdE=0.
    localparam int DE_W = CTRL_W + 15 + 5 * XLEN + 1;

    logic [DE_W-1:0] de_d;
    logic [DE_W-1:0] de_q;

    assign de_d = {bus.CtrlD, bus.Rs1D, bus.Rs2D, bus.RdD, bus.RD1D, bus.RD2D,
                   bus.ImmD, pcd, pcplus4d, validd};

    pipe_reg #(.W(DE_W)) u_id_ex (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (bus.FlushE),
        .d     (de_d),
        .q     (de_q)
    );

    assign {bus.CtrlE, bus.Rs1E, bus.Rs2E, bus.RdE, bus.RD1E, bus.RD2E,
            bus.ImmE, bus.PCE, bus.PCPlus4E, bus.ValidE} = de_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (bus.StallF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (bus.FlushD || bus.FlushE) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign bus.CycleCnt = cycle_cnt;
    assign bus.StallCnt = stall_cnt;
    assign bus.FlushCnt = flush_cnt;
`else
    assign bus.CycleCnt = '0;
    assign bus.StallCnt = '0;
    assign bus.FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_front_regs.sv
// Bench for pipe_front_regs: reset checks, a hand-computed vector table, a reset-mid-stall
// sequence and randomized control traffic compared against a behavioural model.
module tb_pipe_front_regs;

    localparam int          XLEN   = 32;
    localparam int          CTRL_W = 8;
    localparam logic [31:0] RPC    = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_front_regs_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

    pipe_front_regs #(.XLEN(XLEN), .RESET_PC(RPC), .CTRL_W(CTRL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Synthetic instruction memory.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_instr_d, m_pc_d, m_pc4_d;
    logic        m_vd, m_ve;
    logic [7:0]  m_ctrl;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_rd1, m_rd2, m_imm, m_pc_e, m_pc4_e;
    logic [31:0] m_cyc, m_stl, m_fl;

    task automatic model_reset();
        m_pc = RPC; m_instr_d = NOP; m_pc_d = 0; m_pc4_d = 0; m_vd = 0;
        m_ctrl = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
        m_pc_e = 0; m_pc4_e = 0; m_ve = 0;
        m_cyc = 0; m_stl = 0; m_fl = 0;
    endtask

    task automatic compare_all(input string tag);
        exp_q.push_back(m_pc);      exp_q.push_back(m_instr_d); exp_q.push_back(m_pc_d);
        exp_q.push_back(m_pc4_d);   exp_q.push_back({31'd0, m_vd});
        exp_q.push_back({24'd0, m_ctrl}); exp_q.push_back({27'd0, m_rs1});
        exp_q.push_back({27'd0, m_rs2});  exp_q.push_back({27'd0, m_rd});
        exp_q.push_back(m_rd1); exp_q.push_back(m_rd2); exp_q.push_back(m_imm);
        exp_q.push_back(m_pc_e); exp_q.push_back(m_pc4_e); exp_q.push_back({31'd0, m_ve});
        exp_q.push_back(m_cyc); exp_q.push_back(m_stl); exp_q.push_back(m_fl);
        check({tag, ".PCF"},      bus.PCF,              exp_q.pop_front());
        check({tag, ".InstrD"},   bus.InstrD,           exp_q.pop_front());
        check({tag, ".PCD"},      bus.PCD,              exp_q.pop_front());
        check({tag, ".PCPlus4D"}, bus.PCPlus4D,         exp_q.pop_front());
        check({tag, ".ValidD"},   {31'd0, bus.ValidD},  exp_q.pop_front());
        check({tag, ".CtrlE"},    {24'd0, bus.CtrlE},   exp_q.pop_front());
        check({tag, ".Rs1E"},     {27'd0, bus.Rs1E},    exp_q.pop_front());
        check({tag, ".Rs2E"},     {27'd0, bus.Rs2E},    exp_q.pop_front());
        check({tag, ".RdE"},      {27'd0, bus.RdE},     exp_q.pop_front());
        check({tag, ".RD1E"},     bus.RD1E,             exp_q.pop_front());
        check({tag, ".RD2E"},     bus.RD2E,             exp_q.pop_front());
        check({tag, ".ImmE"},     bus.ImmE,             exp_q.pop_front());
        check({tag, ".PCE"},      bus.PCE,              exp_q.pop_front());
        check({tag, ".PCPlus4E"}, bus.PCPlus4E,         exp_q.pop_front());
        check({tag, ".ValidE"},   {31'd0, bus.ValidE},  exp_q.pop_front());
        check({tag, ".CycleCnt"}, bus.CycleCnt,         exp_q.pop_front());
        check({tag, ".StallCnt"}, bus.StallCnt,         exp_q.pop_front());
        check({tag, ".FlushCnt"}, bus.FlushCnt,         exp_q.pop_front());
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic sf, input logic sd, input logic fd, input logic fe,
                         input logic pcs, input logic [31:0] tgt);
        bus.StallF = sf; bus.StallD = sd; bus.FlushD = fd; bus.FlushE = fe;
        bus.PCSrcE = pcs; bus.PCTargetE = tgt;
        bus.InstrF = imem(m_pc);
        bus.CtrlD = 8'($urandom); bus.Rs1D = 5'($urandom); bus.Rs2D = 5'($urandom);
        bus.RdD = 5'($urandom); bus.RD1D = $urandom; bus.RD2D = $urandom; bus.ImmD = $urandom;
    endtask

    // Apply one clock with the currently driven inputs, advance the model, compare.
    task automatic step(input string tag);
        logic [31:0] n_pc, n_instr_d, n_pc_d, n_pc4_d;
        logic        n_vd;
        if (bus.FlushE) begin
            m_ctrl = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
            m_pc_e = 0; m_pc4_e = 0; m_ve = 0;
        end else begin
            m_ctrl = bus.CtrlD; m_rs1 = bus.Rs1D; m_rs2 = bus.Rs2D; m_rd = bus.RdD;
            m_rd1 = bus.RD1D; m_rd2 = bus.RD2D; m_imm = bus.ImmD;
            m_pc_e = m_pc_d; m_pc4_e = m_pc4_d; m_ve = m_vd;
        end
        if (bus.FlushD) begin
            n_instr_d = NOP; n_pc_d = 0; n_pc4_d = 0; n_vd = 0;
        end else if (bus.StallD) begin
            n_instr_d = m_instr_d; n_pc_d = m_pc_d; n_pc4_d = m_pc4_d; n_vd = m_vd;
        end else begin
            n_instr_d = bus.InstrF; n_pc_d = m_pc; n_pc4_d = m_pc + 32'd4; n_vd = 1;
        end
        if (bus.PCSrcE)      n_pc = bus.PCTargetE;
        else if (bus.StallF) n_pc = m_pc;
        else                 n_pc = m_pc + 32'd4;
`ifdef PIPE_PERF_CNT_EN
        m_cyc = m_cyc + 1;
        if (bus.StallF) m_stl = m_stl + 1;
        if (bus.FlushD || bus.FlushE) m_fl = m_fl + 1;
`endif
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr_d = n_instr_d; m_pc_d = n_pc_d; m_pc4_d = n_pc4_d; m_vd = n_vd;
        compare_all(tag);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        sf, sd, fd, fe, pcs;
        logic [31:0] tgt;
        logic [31:0] e_pcf;
        logic [31:0] e_pcd;
        logic        e_vd;
        logic        e_ve;
    } vec_t;

    vec_t tbl[12];

    initial begin
        //          sf sd fd fe pcs  tgt            e_pcf          e_pcd          vd ve
        tbl[0]  = '{0, 0, 0, 0, 0, 32'h0,         32'h0000_0104, 32'h0000_0100, 1, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 32'h0,         32'h0000_0108, 32'h0000_0104, 1, 1};
        tbl[2]  = '{0, 0, 0, 0, 0, 32'h0,         32'h0000_010C, 32'h0000_0108, 1, 1};
        tbl[3]  = '{1, 1, 0, 1, 0, 32'h0,         32'h0000_010C, 32'h0000_0108, 1, 0}; // load-use
        tbl[4]  = '{0, 0, 0, 0, 0, 32'h0,         32'h0000_0110, 32'h0000_010C, 1, 1};
        tbl[5]  = '{0, 0, 1, 0, 1, 32'h200,       32'h0000_0200, 32'h0000_0000, 0, 1}; // branch
        tbl[6]  = '{0, 0, 0, 0, 0, 32'h0,         32'h0000_0204, 32'h0000_0200, 1, 0};
        tbl[7]  = '{0, 1, 1, 0, 0, 32'h0,         32'h0000_0208, 32'h0000_0000, 0, 1}; // flush beats stall
        tbl[8]  = '{1, 0, 0, 0, 1, 32'h300,       32'h0000_0300, 32'h0000_0208, 1, 0}; // redirect beats stall
        tbl[9]  = '{0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0300, 1, 1};
        tbl[10] = '{0, 0, 0, 0, 0, 32'h0,         32'h0000_0000, 32'hFFFF_FFFC, 1, 1}; // wrap
        tbl[11] = '{1, 0, 0, 0, 0, 32'h0,         32'h0000_0000, 32'h0000_0000, 1, 1};
    end

    // ---------------- test sequence ----------------
    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0, 32'h0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");

        rst_n = 1'b1;
        #1;
        check("release.PCF", bus.PCF, RPC);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].sf, tbl[i].sd, tbl[i].fd, tbl[i].fe, tbl[i].pcs, tbl[i].tgt);
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl_PCF", i), bus.PCF, tbl[i].e_pcf);
            check($sformatf("vec%0d.tbl_PCD", i), bus.PCD, tbl[i].e_pcd);
            check($sformatf("vec%0d.tbl_ValidD", i), {31'd0, bus.ValidD}, {31'd0, tbl[i].e_vd});
            check($sformatf("vec%0d.tbl_ValidE", i), {31'd0, bus.ValidE}, {31'd0, tbl[i].e_ve});
            check($sformatf("vec%0d.tbl_InstrD", i), bus.InstrD,
                  tbl[i].e_vd ? imem(tbl[i].e_pcd) : NOP);
            check($sformatf("vec%0d.tbl_PCPlus4D", i), bus.PCPlus4D,
                  tbl[i].e_vd ? tbl[i].e_pcd + 32'd4 : 32'd0);
        end

        // Reset asserted in the middle of a load-use stall cycle.
        drive(1, 1, 0, 1, 0, 32'h0);
        step("pre_rst");
        drive(1, 1, 0, 1, 0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        drive(0, 0, 0, 0, 0, 32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        compare_all("restart");
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 0, 0, 32'h0);
            step($sformatf("restart%0d", i));
            check($sformatf("restart%0d.seq_PCF", i), bus.PCF, RPC + 32'(4 * i));
        end

        // Randomized control traffic.
        for (int i = 0; i < 400; i++) begin
            logic sf, sd, fd, fe, pcs;
            logic [31:0] tgt;
            sf  = ($urandom_range(0, 3) == 0);
            sd  = sf ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            fd  = ($urandom_range(0, 7) == 0);
            fe  = sf ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
            pcs = ($urandom_range(0, 7) == 0);
            tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if ($urandom_range(0, 31) == 0) tgt = 32'hFFFF_FFF8;
            drive(sf, sd, fd, fe, pcs, tgt);
            step($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
